// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: accepts one command per cycle and pipelines its
// address phase over the previous data phase. Responses return in acceptance order.
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL       = 4'b0011,
  parameter logic       ERR_ON_MISALIGN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Sizes above a word are not supported on a 32-bit bus and are issued as words.
  function automatic logic [2:0] bus_size(input logic [2:0] sz);
    return (sz > 3'd2) ? 3'b010 : sz;
  endfunction

  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a);
    logic [2:0] s;
    s = bus_size(sz);
    return ((s == 3'b001) && a[0]) || ((s == 3'b010) && (a != 2'b00));
  endfunction

  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic        dp_lerr_q,  dp_lerr_d;
  logic [31:0] hwdata_q,   hwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic local_err;
  logic issue;
  logic drive_cmd;
  logic dp_done;

  always_comb begin
    local_err = ERR_ON_MISALIGN & misaligned(cmd_size, cmd_addr[1:0]);
    // A pending ERROR response blocks the next address phase until it completes.
    cmd_ready = ~HRESET & HREADY & ~(dp_valid_q & HRESP);
    accept    = cmd_valid & cmd_ready;
    issue     = accept & ~local_err;
    drive_cmd = cmd_valid & ~HRESET;
    dp_done   = dp_valid_q & HREADY;
  end

  always_comb begin
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_lerr_d   = dp_lerr_q;
    hwdata_d    = hwdata_q;
    if (HREADY) begin
      dp_valid_d = accept;
      dp_write_d = accept & cmd_write;
      dp_lerr_d  = accept & local_err;
    end
    if (accept && cmd_write) begin
      hwdata_d = cmd_wdata;
    end
    rsp_valid_d = dp_done;
    rsp_err_d   = dp_done & (dp_lerr_q | HRESP);
    rsp_rdata_d = (dp_done && !dp_write_q && !dp_lerr_q && !HRESP) ? HRDATA : 32'h0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_lerr_q   <= 1'b0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_lerr_q   <= dp_lerr_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    HTRANS    = issue ? TRANS_NONSEQ : TRANS_IDLE;
    HADDR     = drive_cmd ? cmd_addr : 32'h0;
    HWRITE    = drive_cmd & cmd_write;
    HSIZE     = drive_cmd ? bus_size(cmd_size) : 3'b000;
    HBURST    = 3'b000;
    HPROT     = HPROT_VAL;
    HMASTLOCK = 1'b0;
    HWDATA    = hwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_rdata_q;
    busy      = dp_valid_q | rsp_valid_q;
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: per-cycle vector table plus wait-state and reset sequences.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int checks = 0;
  int passes = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {
    logic        v, w;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        rdy, resp;
    logic [31:0] rdata;
    logic        erdy;
    logic [1:0]  etr;
    logic [31:0] eaddr;
    logic [2:0]  esz;
    logic        ewr;
    logic [31:0] ewd;
    logic        erv, eerr;
    logic [31:0] erd;
    logic        ebusy;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(
    input logic v, input logic w, input logic [31:0] addr, input logic [2:0] sz,
    input logic [31:0] wd, input logic rdy, input logic resp, input logic [31:0] rdata,
    input logic erdy, input logic [1:0] etr, input logic [31:0] eaddr, input logic [2:0] esz,
    input logic ewr, input logic [31:0] ewd, input logic erv, input logic eerr,
    input logic [31:0] erd, input logic ebusy);
    vec_t t;
    t.v = v; t.w = w; t.addr = addr; t.sz = sz; t.wd = wd;
    t.rdy = rdy; t.resp = resp; t.rdata = rdata;
    t.erdy = erdy; t.etr = etr; t.eaddr = eaddr; t.esz = esz; t.ewr = ewr;
    t.ewd = ewd; t.erv = erv; t.eerr = eerr; t.erd = erd; t.ebusy = ebusy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic rdy, input logic resp,
                       input logic [31:0] rd);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    HREADY = rdy; HRESP = resp; HRDATA = rd;
  endtask

  initial begin
    // Write 0x1000 zero-wait
    vecs[0]  = mk(1,1,32'h1000,3'd2,32'hA5,1,0,0,  1,2'b10,32'h1000,3'd2,1,32'h0,  0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           0,0,0,1);
    vecs[2]  = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           1,0,0,1);
    vecs[3]  = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           0,0,0,0);
    // Back-to-back reads 0x0, 0x4
    vecs[4]  = mk(1,0,32'h0,3'd2,0,1,0,0,          1,2'b10,32'h0,3'd2,0,32'hA5,    0,0,0,0);
    vecs[5]  = mk(1,0,32'h4,3'd2,0,1,0,32'h11,     1,2'b10,32'h4,3'd2,0,32'hA5,    0,0,0,1);
    vecs[6]  = mk(0,0,0,0,0,1,0,32'h22,            1,2'b00,0,0,0,32'hA5,           1,0,32'h11,1);
    vecs[7]  = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           1,0,32'h22,1);
    vecs[8]  = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           0,0,0,0);
    // Misaligned word at 0x2 between aligned reads
    vecs[9]  = mk(1,0,32'h10,3'd2,0,1,0,0,         1,2'b10,32'h10,3'd2,0,32'hA5,   0,0,0,0);
    vecs[10] = mk(1,0,32'h2,3'd2,0,1,0,32'h33,     1,2'b00,32'h2,3'd2,0,32'hA5,    0,0,0,1);
    vecs[11] = mk(1,0,32'h14,3'd2,0,1,0,32'hDEADBEEF, 1,2'b10,32'h14,3'd2,0,32'hA5, 1,0,32'h33,1);
    vecs[12] = mk(0,0,0,0,0,1,0,32'h44,            1,2'b00,0,0,0,32'hA5,           1,1,0,1);
    vecs[13] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           1,0,32'h44,1);
    vecs[14] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           0,0,0,0);
    // Read 0x8 gets two-cycle ERROR, read 0xC queued behind it
    vecs[15] = mk(1,0,32'h8,3'd2,0,1,0,0,          1,2'b10,32'h8,3'd2,0,32'hA5,    0,0,0,0);
    vecs[16] = mk(1,0,32'hC,3'd2,0,0,1,32'hBAD,    0,2'b00,32'hC,3'd2,0,32'hA5,    0,0,0,1);
    vecs[17] = mk(1,0,32'hC,3'd2,0,1,1,32'hBAD,    0,2'b00,32'hC,3'd2,0,32'hA5,    0,0,0,1);
    vecs[18] = mk(1,0,32'hC,3'd2,0,1,0,0,          1,2'b10,32'hC,3'd2,0,32'hA5,    1,1,0,1);
    vecs[19] = mk(0,0,0,0,0,1,0,32'h55,            1,2'b00,0,0,0,32'hA5,           0,0,0,1);
    vecs[20] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           1,0,32'h55,1);
    vecs[21] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'hA5,           0,0,0,0);
    // Misaligned half write, oversize read, byte write
    vecs[22] = mk(1,1,32'h21,3'd1,32'h1234,1,0,0,  1,2'b00,32'h21,3'd1,1,32'hA5,   0,0,0,0);
    vecs[23] = mk(1,0,32'h30,3'd3,0,1,0,0,         1,2'b10,32'h30,3'd2,0,32'h1234, 0,0,0,1);
    vecs[24] = mk(1,1,32'h23,3'd0,32'h77000000,1,0,32'h66, 1,2'b10,32'h23,3'd0,1,32'h1234, 1,1,0,1);
    vecs[25] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'h77000000,     1,0,32'h66,1);
    vecs[26] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'h77000000,     1,0,0,1);
    vecs[27] = mk(0,0,0,0,0,1,0,0,                 1,2'b00,0,0,0,32'h77000000,     0,0,0,0);

    HRESET = 1'b1;
    drive(1, 1, 32'h999, 3'd2, 32'hFFFF, 1, 0, 0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    chk("rst.cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("rst.htrans",    {30'b0, HTRANS}, 32'h0);
    chk("rst.haddr",     HADDR, 32'h0);
    chk("rst.hwrite",    {31'b0, HWRITE}, 32'h0);
    chk("rst.hsize",     {29'b0, HSIZE}, 32'h0);
    chk("rst.hwdata",    HWDATA, 32'h0);
    chk("rst.hprot",     {28'b0, HPROT}, 32'h3);
    chk("rst.hburst",    {29'b0, HBURST}, 32'h0);
    chk("rst.hmastlock", {31'b0, HMASTLOCK}, 32'h0);
    chk("rst.rsp",       {rsp_rdata[30:0], rsp_valid}, 32'h0);
    chk("rst.rsp_err",   {31'b0, rsp_err}, 32'h0);
    chk("rst.busy",      {31'b0, busy}, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    HRESET = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge HCLK);
      drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].sz, vecs[i].wd,
            vecs[i].rdy, vecs[i].resp, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d.cmd_ready", i), {31'b0, cmd_ready}, {31'b0, vecs[i].erdy});
      chk($sformatf("v%0d.htrans", i),    {30'b0, HTRANS}, {30'b0, vecs[i].etr});
      chk($sformatf("v%0d.haddr", i),     HADDR, vecs[i].eaddr);
      chk($sformatf("v%0d.hsize", i),     {29'b0, HSIZE}, {29'b0, vecs[i].esz});
      chk($sformatf("v%0d.hwrite", i),    {31'b0, HWRITE}, {31'b0, vecs[i].ewr});
      chk($sformatf("v%0d.hwdata", i),    HWDATA, vecs[i].ewd);
      chk($sformatf("v%0d.rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].erv});
      chk($sformatf("v%0d.rsp_err", i),   {31'b0, rsp_err}, {31'b0, vecs[i].eerr});
      chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, vecs[i].erd);
      chk($sformatf("v%0d.busy", i),      {31'b0, busy}, {31'b0, vecs[i].ebusy});
    end

    // Write 0x40 with three wait states, read 0x44 waiting behind it
    @(negedge HCLK);
    drive(1, 1, 32'h40, 3'd2, 32'hDEADBEEF, 1, 0, 0);
    #1;
    chk("ws.accept.htrans", {30'b0, HTRANS}, 32'h2);
    chk("ws.accept.ready",  {31'b0, cmd_ready}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge HCLK);
      drive(1, 0, 32'h44, 3'd2, 0, 0, 0, 0);
      #1;
      chk($sformatf("ws%0d.cmd_ready", k), {31'b0, cmd_ready}, 32'h0);
      chk($sformatf("ws%0d.htrans", k),    {30'b0, HTRANS}, 32'h0);
      chk($sformatf("ws%0d.hwdata", k),    HWDATA, 32'hDEADBEEF);
      chk($sformatf("ws%0d.haddr", k),     HADDR, 32'h44);
      chk($sformatf("ws%0d.rsp_valid", k), {31'b0, rsp_valid}, 32'h0);
    end
    @(negedge HCLK);
    drive(1, 0, 32'h44, 3'd2, 0, 1, 0, 0);
    #1;
    chk("ws4.cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("ws4.htrans",    {30'b0, HTRANS}, 32'h2);
    chk("ws4.hwdata",    HWDATA, 32'hDEADBEEF);
    chk("ws4.haddr",     HADDR, 32'h44);
    chk("ws4.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h99);
    #1;
    chk("ws5.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("ws5.rsp_err",   {31'b0, rsp_err}, 32'h0);
    chk("ws5.rsp_rdata", rsp_rdata, 32'h0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("ws6.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("ws6.rsp_rdata", rsp_rdata, 32'h99);
    @(negedge HCLK);
    #1;
    chk("ws7.busy", {31'b0, busy}, 32'h0);

    // Reset asserted during a waited data phase
    @(negedge HCLK);
    drive(1, 0, 32'h50, 3'd2, 0, 1, 0, 0);
    #1;
    chk("mr.issue", {30'b0, HTRANS}, 32'h2);
    @(negedge HCLK);
    drive(1, 0, 32'h54, 3'd2, 0, 0, 0, 0);
    #1;
    chk("mr.busy_before", {31'b0, busy}, 32'h1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("mr.htrans",    {30'b0, HTRANS}, 32'h0);
    chk("mr.haddr",     HADDR, 32'h0);
    chk("mr.hwdata",    HWDATA, 32'h0);
    chk("mr.cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("mr.busy",      {31'b0, busy}, 32'h0);
    chk("mr.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(1, 0, 32'h60, 3'd2, 0, 1, 0, 0);
    #1;
    chk("rel.first_issue", {30'b0, HTRANS}, 32'h2);
    chk("rel.rsp_valid0",  {31'b0, rsp_valid}, 32'h0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 32'hAB);
    #1;
    chk("rel.rsp_valid1",  {31'b0, rsp_valid}, 32'h0);
    chk("rel.busy1",       {31'b0, busy}, 32'h1);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("rel.rsp_valid2",  {31'b0, rsp_valid}, 32'h1);
    chk("rel.rsp_rdata2",  rsp_rdata, 32'hAB);
    @(negedge HCLK);
    #1;
    chk("rel.busy3",       {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
